awp_wb: RTL and testbench
=========================

// Module: awp_wb
// PURPOSE
// - Write-back stage downstream of the AWP coprocessor.
// - Captures result words that the AWP drives on zp, tagged with the target register r1..r3 (lpa/lpb), queues them, and writes them into the CPU register file via a req/ack handshake.
// - Latches the AWP exception flags fi0..fi3 as sticky interrupt requests.
// - Signals CPU completion only after ekc_fp has been seen and every queued word has been written.
// PARAMETERS
// - DEPTH  4  write-back queue entries; power of 2, >=4 (covers a 3-word float result plus 1 slack)
// PORTS
// - clk_sys    in   1     system clock; all state changes on rising edge
// - clr        in   1     asynchronous, active-high reset
// - zp         in   16    AWP result bus, bits [0:15], MSB=0
// - lpa, lpb   in   1     register select {lpa,lpb}: 01=r1, 10=r2, 11=r3, 00=none
// - rlp_fp     in   1     AWP register access active
// - s_fp       in   1     AWP result direction (ZP->W)
// - strob_fp   in   1     AWP strobe level (multi-cycle)
// - ustr0_fp   in   1     AWP flag-set request
// - fi         in   4     {fi0,fi1,fi2,fi3}: fixed ovf, float underflow, float overflow, div/0
// - ekc_fp     in   1     AWP operation finished (level)
// - wr_req     out  1     register-file write request
// - wr_sel     out  2     target register code (as lpa/lpb)
// - wr_data    out  16    word to write, [0:15]
// - wr_ack     in   1     register file accepted the word this cycle
// - irq        out  4     sticky AWP interrupt requests, same order as fi
// - irq_ack    in   4     per-bit clear of irq
// - wb_busy    out  1     queue non-empty or state != IDLE
// - awp_done   out  1     one-cycle completion pulse to CPU
// - ovf        out  1     sticky: a word was dropped because the queue was full
// BEHAVIOUR
// - Reset: queue empty; state IDLE; all outputs 0; strobe edge register 0.
// - Capture:
//   - cap = strob_fp & ~strob_q & rlp_fp & s_fp & ({lpa,lpb}!=0), where strob_q = strob_fp delayed one clk.
//   - One push per strobe, of {lpa,lpb, zp} sampled in the cap cycle.
//   - Selector 00: no push.
// - Queue: DEPTH-entry circular FIFO of 18-bit entries, ptrs wrap mod DEPTH, count 0..DEPTH.
//   - Full + cap: word dropped, ovf<=1 (cleared only by clr).
//   - Push and pop in the same cycle: both performed, count unchanged. Legal at full, so nothing is dropped.
// - Write port:
//   - wr_req, wr_sel and wr_data are registered and present the head entry.
//   - wr_req=1 the cycle after the entry lands in an empty queue, i.e. 1 clk latency cap->wr_req.
//   - Fields stay stable while wr_req & ~wr_ack.
//   - Pop on wr_req & wr_ack. The next entry is offered the following cycle; wr_req drops if the queue is empty.
// - Flags:
//   - On the rising edge of ustr0_fp: irq <= irq | fi.
//   - irq_ack[i] clears irq[i].
//   - Set and ack of the same bit in the same cycle: set wins.
// - FSM (state in awp_pkg):
//   - IDLE -> COLLECT on first cap or rising rlp_fp.
//   - COLLECT -> DRAIN on ekc_fp=1 while queue non-empty.
//   - COLLECT -> DONE on ekc_fp=1 while queue empty, or when the last pop happens in the same cycle as ekc_fp.
//   - DRAIN -> DONE when the last entry pops.
//   - DONE: awp_done=1 for exactly one cycle -> WAIT_EKC.
//   - WAIT_EKC -> IDLE when ekc_fp=0 (prevents a second pulse from one level).
//   - cap in DRAIN or DONE: still pushed. DONE is deferred to DRAIN until the queue is empty.
// - Reset mid-operation: queue flushed, pending writes lost, irq cleared, no awp_done pulse.
// STRUCTURE
// - awp_pkg:
//   - localparams REG_NONE/R1/R2/R3 (2'b00..2'b11)
//   - FSM encoding IDLE, COLLECT, DRAIN, DONE, WAIT_EKC
//   - entry width 18
// - Sub-module awp_wb_fifo: DEPTH x 18 FIFO with push/pop/full/empty/count and clr.
//   - Top level holds edge detection, irq latch, FSM and output registers.
// TESTING
// - Float result: 3 caps to r1=16'h4000, r2=16'h0001, r3=16'h8000, wr_ack tied 1, ekc_fp after 3rd
//   -> 3 writes in order, 1 clk after each cap; awp_done once, after the r3 write.
// - Back-pressure: 3 caps with wr_ack=0 for 10 clk, then ekc_fp, then wr_ack=1
//   -> wr_req held with r1 data stable; no awp_done until the 3rd pop, then exactly 1 pulse.
// - Overflow: 5 caps with wr_ack=0 (DEPTH=4)
//   -> 4 queued, 5th dropped, ovf=1; push+pop at full with wr_ack=1 leaves ovf unchanged, no further loss.
// - Flags: ustr0_fp rise with fi=4'b0101 -> irq=0101; irq_ack=0001 in the same cycle as a new set fi=0001 -> irq=0101.
// - Long ekc_fp: held 20 clk -> single awp_done pulse; next op starts only after ekc_fp=0.
// - clr during DRAIN with 2 entries queued -> wr_req=0, irq=0, wb_busy=0, no awp_done.

Source files
------------

// File: rtl/awp_pkg.sv
// Shared definitions for the AWP write-back stage: register-select codes,
// FSM state encoding and the queue entry layout.
package awp_pkg;

  // Register-select codes as carried on {lpa,lpb}
  localparam logic [1:0] REG_NONE = 2'b00;
  localparam logic [1:0] REG_R1   = 2'b01;
  localparam logic [1:0] REG_R2   = 2'b10;
  localparam logic [1:0] REG_R3   = 2'b11;

  // Write-back FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_WAIT_EKC = 3'd4;

  localparam int ENTRY_W = 18;

  // Queue entry: target register code plus the 16-bit result word
  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
  } entry_t;

endpackage

// File: rtl/awp_wb_fifo.sv
// Circular write-back queue of DEPTH entries.
// Ports:
//   clk, clr       clock and asynchronous active-high reset (pointers/count only)
//   push, pop      enqueue din / dequeue head; push at full is honoured only
//                  together with a pop
//   din            entry to enqueue
//   head           entry at the read pointer
//   head_nxt       entry one slot behind the head (next head after a pop)
//   full, empty    occupancy flags
//   count          number of valid entries, 0..DEPTH
module awp_wb_fifo
  import awp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   head,
  output entry_t                   head_nxt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + AW'(1)];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/awp_wb.sv
// Write-back stage behind the AWP coprocessor. Captures result words strobed
// onto zp, queues them and writes them to the CPU register file over a
// req/ack port; latches AWP exception flags as sticky interrupts; pulses
// awp_done once per operation after ekc_fp and a fully drained queue.
// Ports:
//   clk_sys, clr                clock, asynchronous active-high reset
//   zp, lpa, lpb                result word and target register select
//   rlp_fp, s_fp, strob_fp      AWP register access, direction, strobe level
//   ustr0_fp, fi                flag-set request and flag vector
//   ekc_fp                      AWP operation finished (level)
//   wr_req, wr_sel, wr_data     register-file write request and payload
//   wr_ack                      register file accepted the word
//   irq, irq_ack                sticky interrupt requests and per-bit clear
//   wb_busy, awp_done, ovf      status: busy, completion pulse, sticky drop
module awp_wb
  import awp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        clr,
  input  logic [0:15] zp,
  input  logic        lpa,
  input  logic        lpb,
  input  logic        rlp_fp,
  input  logic        s_fp,
  input  logic        strob_fp,
  input  logic        ustr0_fp,
  input  logic [3:0]  fi,
  input  logic        ekc_fp,
  output logic        wr_req,
  output logic [1:0]  wr_sel,
  output logic [0:15] wr_data,
  input  logic        wr_ack,
  output logic [3:0]  irq,
  input  logic [3:0]  irq_ack,
  output logic        wb_busy,
  output logic        awp_done,
  output logic        ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          strob_q;
  logic          rlp_q;
  logic          ustr_q;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [1:0]    sel;
  logic          cap;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  entry_t        cap_entry;
  entry_t        head;
  entry_t        head_nxt;
  entry_t        out_nxt;
  logic          out_load;

  assign sel       = {lpa, lpb};
  assign cap       = strob_fp & ~strob_q & rlp_fp & s_fp & (sel != REG_NONE);
  assign pop       = wr_req & wr_ack;
  // A push at full is legal when the head leaves in the same cycle
  assign push      = cap & (~full | pop);
  assign drop      = cap & full & ~pop;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign cap_entry = '{sel: sel, data: zp};

  awp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk_sys),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .din      (cap_entry),
    .head     (head),
    .head_nxt (head_nxt),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // The write port is registered, so work out what the head will be after
  // this cycle's push/pop. A word landing in an empty (or just-emptied)
  // queue bypasses storage to meet the one-clock cap->wr_req latency.
  always_comb begin
    out_load = 1'b0;
    out_nxt  = head;
    if (pop && (count > CW'(1))) begin
      out_load = 1'b1;
      out_nxt  = head_nxt;
    end else if (push && ((count == '0) || (pop && (count == CW'(1))))) begin
      out_load = 1'b1;
      out_nxt  = cap_entry;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cap || (rlp_fp && !rlp_q)) state_nxt = ST_COLLECT;
      ST_COLLECT:  if (ekc_fp) state_nxt = (count_nxt == '0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN:    if (count_nxt == '0) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_WAIT_EKC;
      // Hold here while ekc_fp stays high so one level gives one pulse
      ST_WAIT_EKC: if (!ekc_fp) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      strob_q <= 1'b0;
      rlp_q   <= 1'b0;
      ustr_q  <= 1'b0;
      state   <= ST_IDLE;
      wr_req  <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
      irq     <= '0;
      ovf     <= 1'b0;
    end else begin
      strob_q <= strob_fp;
      rlp_q   <= rlp_fp;
      ustr_q  <= ustr0_fp;
      state   <= state_nxt;
      wr_req  <= (count_nxt != '0);
      if (out_load) {wr_sel, wr_data} <= out_nxt;
      // Ack is applied before the set so a simultaneous set wins
      irq     <= (irq & ~irq_ack) | ((ustr0_fp && !ustr_q) ? fi : 4'b0000);
      ovf     <= ovf | drop;
    end
  end

  assign awp_done = (state == ST_DONE);
  assign wb_busy  = ~empty | (state != ST_IDLE);

endmodule

// File: tb/tb_awp_wb.sv
module tb_awp_wb;
  import awp_pkg::*;

  logic        clk_sys = 1'b0;
  logic        clr;
  logic [0:15] zp;
  logic        lpa, lpb, rlp_fp, s_fp, strob_fp, ustr0_fp, ekc_fp;
  logic [3:0]  fi;
  logic        wr_req;
  logic [1:0]  wr_sel;
  logic [0:15] wr_data;
  logic        wr_ack;
  logic [3:0]  irq, irq_ack;
  logic        wb_busy, awp_done, ovf;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb[$];
  int          done_pulses = 0;
  int          writes = 0;

  awp_wb #(.DEPTH(4)) dut (
    .clk_sys  (clk_sys),
    .clr      (clr),
    .zp       (zp),
    .lpa      (lpa),
    .lpb      (lpb),
    .rlp_fp   (rlp_fp),
    .s_fp     (s_fp),
    .strob_fp (strob_fp),
    .ustr0_fp (ustr0_fp),
    .fi       (fi),
    .ekc_fp   (ekc_fp),
    .wr_req   (wr_req),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .irq      (irq),
    .irq_ack  (irq_ack),
    .wb_busy  (wb_busy),
    .awp_done (awp_done),
    .ovf      (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    rlp_fp = 1'b0; s_fp = 1'b0; strob_fp = 1'b0; ustr0_fp = 1'b0;
    ekc_fp = 1'b0; wr_ack = 1'b0; irq_ack = 4'b0; fi = 4'b0;
    sb.delete();
    tick();
    clr = 1'b0;
    tick();
  endtask

  // One strobe: high for one edge, low for the next
  task automatic cap(input logic [1:0] sel, input logic [15:0] d, input bit accept, input bit chk_lat);
    {lpa, lpb} = sel;
    zp = d;
    rlp_fp = 1'b1;
    s_fp = 1'b1;
    strob_fp = 1'b1;
    if (accept) sb.push_back({sel, d});
    tick();
    if (chk_lat) begin
      check("cap_latency_req", 32'(wr_req), 32'd1);
      check("cap_latency_word", 32'({wr_sel, wr_data}), 32'({sel, d}));
    end
    strob_fp = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every accepted write must match the next queued word
  initial begin
    logic [17:0] exp;
    forever begin
      @(negedge clk_sys);
      if (clr === 1'b0 && wr_req === 1'b1 && wr_ack === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h required no write", {wr_sel, wr_data});
        end else begin
          exp = sb.pop_front();
          check("write_word", 32'({wr_sel, wr_data}), 32'(exp));
          writes++;
        end
      end
      if (clr === 1'b0 && awp_done === 1'b1) begin
        done_pulses++;
        check("done_after_drain", 32'(sb.size()), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wbase;
    bit stable;

    clr = 1'b1; zp = '0; lpa = 0; lpb = 0; rlp_fp = 0; s_fp = 0; strob_fp = 0;
    ustr0_fp = 0; fi = 0; ekc_fp = 0; wr_ack = 0; irq_ack = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_wr_data", 32'({wr_sel, wr_data}), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(wb_busy), 32'd0);
    check("rst_done", 32'(awp_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    clr = 1'b0;
    tick();

    // Float result with wr_ack tied high
    do_clr();
    wr_ack = 1'b1;
    base = done_pulses;
    wbase = writes;
    cap(REG_R1, 16'h4000, 1, 1);
    cap(REG_R2, 16'h0001, 1, 1);
    cap(REG_R3, 16'h8000, 1, 1);
    ekc_fp = 1'b1;
    repeat (3) tick();
    check("float_done_once", 32'(done_pulses - base), 32'd1);
    check("float_writes", 32'(writes - wbase), 32'd3);
    ekc_fp = 1'b0;
    repeat (2) tick();
    check("float_idle", 32'(wb_busy), 32'd0);
    cap(REG_NONE, 16'hdead, 0, 0);
    check("sel00_no_req", 32'(wr_req), 32'd0);
    check("sel00_idle", 32'(wb_busy), 32'd0);

    // Back-pressure
    do_clr();
    cap(REG_R1, 16'h1234, 1, 0);
    cap(REG_R2, 16'h5678, 1, 0);
    cap(REG_R3, 16'h9abc, 1, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (wr_req !== 1'b1 || {wr_sel, wr_data} !== {REG_R1, 16'h1234}) stable = 1'b0;
      tick();
    end
    check("bp_hold_stable", 32'(stable), 32'd1);
    check("bp_head_word", 32'({wr_sel, wr_data}), 32'({REG_R1, 16'h1234}));
    base = done_pulses;
    ekc_fp = 1'b1;
    repeat (3) tick();
    check("bp_no_early_done", 32'(done_pulses - base), 32'd0);
    wr_ack = 1'b1;
    repeat (6) tick();
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_done_once", 32'(done_pulses - base), 32'd1);
    ekc_fp = 1'b0;
    repeat (2) tick();
    check("bp_idle", 32'(wb_busy), 32'd0);

    // Overflow at DEPTH=4
    do_clr();
    cap(REG_R1, 16'h0001, 1, 0);
    cap(REG_R2, 16'h0002, 1, 0);
    cap(REG_R3, 16'h0003, 1, 0);
    cap(REG_R1, 16'h0004, 1, 0);
    check("ovf_clear_at_full", 32'(ovf), 32'd0);
    cap(REG_R2, 16'h0005, 0, 0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_head", 32'({wr_sel, wr_data}), 32'({REG_R1, 16'h0001}));
    wr_ack = 1'b1;
    cap(REG_R3, 16'h0006, 1, 0);
    repeat (6) tick();
    check("ovf_full_pushpop_drained", 32'(sb.size()), 32'd0);
    check("ovf_req_low", 32'(wr_req), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Flags
    do_clr();
    fi = 4'b0101;
    ustr0_fp = 1'b1;
    tick();
    check("irq_set", 32'(irq), 32'h5);
    ustr0_fp = 1'b0;
    tick();
    fi = 4'b0001;
    irq_ack = 4'b0001;
    ustr0_fp = 1'b1;
    tick();
    irq_ack = 4'b0000;
    check("irq_set_wins", 32'(irq), 32'h5);
    fi = 4'b1111;
    irq_ack = 4'b0100;
    tick();
    irq_ack = 4'b0000;
    check("irq_ack_no_edge", 32'(irq), 32'h1);
    ustr0_fp = 1'b0;
    tick();

    // Long ekc_fp
    do_clr();
    wr_ack = 1'b1;
    rlp_fp = 1'b1;
    tick();
    check("rlp_rise_busy", 32'(wb_busy), 32'd1);
    cap(REG_R2, 16'h0042, 1, 0);
    base = done_pulses;
    ekc_fp = 1'b1;
    repeat (20) tick();
    check("long_ekc_one_pulse", 32'(done_pulses - base), 32'd1);
    check("long_ekc_wait", 32'(wb_busy), 32'd1);
    ekc_fp = 1'b0;
    tick();
    check("long_ekc_release", 32'(wb_busy), 32'd0);
    cap(REG_R3, 16'h0007, 1, 0);
    ekc_fp = 1'b1;
    repeat (4) tick();
    check("second_op_pulse", 32'(done_pulses - base), 32'd2);
    ekc_fp = 1'b0;
    repeat (2) tick();

    // Reset during DRAIN
    do_clr();
    cap(REG_R1, 16'haaaa, 1, 0);
    cap(REG_R2, 16'hbbbb, 1, 0);
    ekc_fp = 1'b1;
    tick();
    fi = 4'b1000;
    ustr0_fp = 1'b1;
    tick();
    ustr0_fp = 1'b0;
    check("drain_irq", 32'(irq), 32'h8);
    check("drain_req", 32'(wr_req), 32'd1);
    base = done_pulses;
    sb.delete();
    clr = 1'b1;
    #1;
    check("clr_req", 32'(wr_req), 32'd0);
    check("clr_irq", 32'(irq), 32'd0);
    check("clr_busy", 32'(wb_busy), 32'd0);
    tick();
    clr = 1'b0;
    ekc_fp = 1'b0;
    repeat (5) tick();
    check("clr_no_done", 32'(done_pulses - base), 32'd0);
    check("clr_req_stays_low", 32'(wr_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
